// File: rtl/reg_file.sv
// reg_file: x0..x31 values with per-register busy/ROB-tag renaming, commit/rename/flush updates, two bypassed combinational query ports and a busy count
module reg_file #(
  parameter int ROB_SIZE_BIT = 5
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    rob_clear,
  input  logic                    is_update_val,
  input  logic [4:0]              update_val_id,
  input  logic [ROB_SIZE_BIT-1:0] update_val_dep,
  input  logic [31:0]             update_val,
  input  logic                    is_update_dep,
  input  logic [4:0]              update_dep_id,
  input  logic [ROB_SIZE_BIT-1:0] update_dep,
  input  logic [4:0]              qry1_reg_id,
  output logic                    qry1_busy,
  output logic [31:0]             qry1_value,
  output logic [ROB_SIZE_BIT-1:0] qry1_dep,
  input  logic [4:0]              qry2_reg_id,
  output logic                    qry2_busy,
  output logic [31:0]             qry2_value,
  output logic [ROB_SIZE_BIT-1:0] qry2_dep,
  output logic [5:0]              busy_cnt
);
  logic [31:0]             value [32];
  logic [ROB_SIZE_BIT-1:0] dep [32];
  logic [31:0]             busy, busy_nxt;
  logic [5:0]              cnt_nxt;
  logic                    hit1, hit2;
  always_comb begin
    busy_nxt = '0;
    cnt_nxt = '0;
    for (int i = 1; i < 32; i++) begin
      busy_nxt[i] = rob_clear ? 1'b0 :
                    (is_update_dep && update_dep_id == 5'(i)) ? 1'b1 :
                    (is_update_val && update_val_id == 5'(i) && dep[i] == update_val_dep) ? 1'b0 :
                    busy[i];
      cnt_nxt = cnt_nxt + 6'(busy_nxt[i]);
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      value <= '{default: '0};
      dep <= '{default: '0};
      busy <= '0;
      busy_cnt <= '0;
    end else if (rdy_in) begin
      if (is_update_val && update_val_id != 5'd0) value[update_val_id] <= update_val;
      if (!rob_clear && is_update_dep && update_dep_id != 5'd0) dep[update_dep_id] <= update_dep;
      busy <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
  assign hit1 = is_update_val && update_val_id == qry1_reg_id && busy[qry1_reg_id] && dep[qry1_reg_id] == update_val_dep;
  assign hit2 = is_update_val && update_val_id == qry2_reg_id && busy[qry2_reg_id] && dep[qry2_reg_id] == update_val_dep;
  assign qry1_busy = qry1_reg_id != 5'd0 && busy[qry1_reg_id] && !hit1;
  assign qry2_busy = qry2_reg_id != 5'd0 && busy[qry2_reg_id] && !hit2;
  assign qry1_value = qry1_reg_id == 5'd0 ? '0 : hit1 ? update_val : value[qry1_reg_id];
  assign qry2_value = qry2_reg_id == 5'd0 ? '0 : hit2 ? update_val : value[qry2_reg_id];
  assign qry1_dep = qry1_reg_id == 5'd0 ? '0 : dep[qry1_reg_id];
  assign qry2_dep = qry2_reg_id == 5'd0 ? '0 : dep[qry2_reg_id];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: table-driven scoreboard bench for reg_file
module tb_reg_file;
  logic        clk_in = 0, rst_in, rdy_in, rob_clear;
  logic        is_update_val, is_update_dep;
  logic [4:0]  update_val_id, update_val_dep, update_dep_id, update_dep;
  logic [31:0] update_val;
  logic [4:0]  qry1_reg_id, qry2_reg_id, qry1_dep, qry2_dep;
  logic        qry1_busy, qry2_busy;
  logic [31:0] qry1_value, qry2_value;
  logic [5:0]  busy_cnt;
  int n_vec = 0, n_fail = 0;
  reg_file #(.ROB_SIZE_BIT(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .is_update_val(is_update_val), .update_val_id(update_val_id), .update_val_dep(update_val_dep), .update_val(update_val),
    .is_update_dep(is_update_dep), .update_dep_id(update_dep_id), .update_dep(update_dep),
    .qry1_reg_id(qry1_reg_id), .qry1_busy(qry1_busy), .qry1_value(qry1_value), .qry1_dep(qry1_dep),
    .qry2_reg_id(qry2_reg_id), .qry2_busy(qry2_busy), .qry2_value(qry2_value), .qry2_dep(qry2_dep),
    .busy_cnt(busy_cnt)
  );
  always #5 clk_in = ~clk_in;
  typedef struct {
    logic rdy, clr, iv; logic [4:0] vid, vdep; logic [31:0] val;
    logic idp; logic [4:0] did, ddep, q1, q2;
  } in_t;
  typedef struct {
    logic b1; logic [31:0] v1; logic [4:0] d1;
    logic b2; logic [31:0] v2; logic [4:0] d2;
    logic xd; logic [5:0] cnt;
  } exp_t;
  typedef struct { in_t i; exp_t e; } vec_t;
  vec_t tbl[$];
  exp_t sb[$];
  function automatic vec_t mk(logic rdy, logic clr, logic iv, logic [4:0] vid, logic [4:0] vdep, logic [31:0] val,
                              logic idp, logic [4:0] did, logic [4:0] ddep, logic [4:0] q1, logic [4:0] q2,
                              logic b1, logic [31:0] v1, logic [4:0] d1, logic b2, logic [31:0] v2, logic [4:0] d2,
                              logic xd, logic [5:0] cnt);
    vec_t v;
    v.i = '{rdy, clr, iv, vid, vdep, val, idp, did, ddep, q1, q2};
    v.e = '{b1, v1, d1, b2, v2, d2, xd, cnt};
    return v;
  endfunction
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got %h, expected %h", nm, idx, act, exp);
    end
  endtask
  task automatic idle();
    rdy_in = 1; rob_clear = 0; is_update_val = 0; is_update_dep = 0;
    update_val_id = 0; update_val_dep = 0; update_val = 0; update_dep_id = 0; update_dep = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    exp_t e;
    //             rdy clr iv vid vdep val          idp did ddep q1 q2 | b1 v1          d1 b2 v2          d2 xd cnt
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              0, 0, 0,  5, 5,    0, 0,          0, 0, 0,          0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              1, 3, 7,  3, 3,    0, 0,          0, 0, 0,          0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 3, 7, 32'h12345678,   0, 0, 0,  3, 3,    0, 32'h12345678, 7, 0, 32'h12345678, 7, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              0, 0, 0,  3, 0,    0, 32'h12345678, 7, 0, 0,          0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              1, 4, 2,  4, 4,    0, 0,          0, 0, 0,          0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              1, 4, 9,  4, 4,    1, 0,          2, 1, 0,          2, 0, 1));
    tbl.push_back(mk(1, 0, 1, 4, 2, 32'hAA,         0, 0, 0,  4, 4,    1, 0,          9, 1, 0,          9, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              0, 0, 0,  4, 3,    1, 32'hAA,     9, 0, 32'h12345678, 7, 0, 1));
    tbl.push_back(mk(1, 0, 1, 6, 1, 32'hC0DE,       1, 6, 4,  6, 4,    0, 0,          0, 1, 32'hAA,     9, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              0, 0, 0,  6, 4,    1, 32'hC0DE,   4, 1, 32'hAA,     9, 0, 2));
    tbl.push_back(mk(1, 0, 1, 4, 9, 32'hBB,         0, 0, 0,  4, 6,    0, 32'hBB,     9, 1, 32'hC0DE,   4, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              1, 7, 5,  7, 7,    0, 0,          0, 0, 0,          0, 0, 2));
    tbl.push_back(mk(1, 0, 1, 7, 5, 32'h77,         1, 7, 6,  7, 7,    0, 32'h77,     5, 0, 32'h77,     5, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              0, 0, 0,  7, 4,    1, 32'h77,     6, 0, 32'hBB,     9, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,              0, 0, 0,  6, 7,    1, 32'hC0DE,   4, 1, 32'h77,     6, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              1, 1, 1,  1, 2,    0, 0,          0, 0, 0,          0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              1, 2, 2,  1, 2,    1, 0,          1, 0, 0,          0, 1, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              1, 10, 3, 10, 2,   0, 0,          0, 1, 0,          2, 1, 3));
    tbl.push_back(mk(1, 1, 1, 2, 2, 32'h55,         1, 5, 8,  1, 2,    1, 0,          1, 0, 32'h55,     2, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              0, 0, 0,  2, 5,    0, 32'h55,     0, 0, 0,          0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              0, 0, 0,  10, 1,   0, 0,          0, 0, 0,          0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 32'hFFFFFFFF,   1, 0, 3,  0, 0,    0, 0,          0, 0, 0,          0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              0, 0, 0,  0, 0,    0, 0,          0, 0, 0,          0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,              1, 8, 5,  8, 8,    0, 0,          0, 0, 0,          0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 32'h99,         0, 0, 0,  8, 2,    0, 0,          0, 0, 32'h55,     0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              0, 0, 0,  8, 2,    0, 0,          0, 0, 32'h55,     0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              1, 8, 5,  8, 8,    0, 0,          0, 0, 0,          0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,              0, 0, 0,  8, 3,    1, 0,          5, 0, 32'h12345678, 7, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,              0, 0, 0,  8, 8,    1, 0,          5, 1, 0,          5, 0, 1));
    idle(); qry1_reg_id = 5; qry2_reg_id = 5;
    rst_in = 1;
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset busy_cnt", -1, 32'(busy_cnt), 0);
    @(negedge clk_in); rst_in = 0;
    foreach (tbl[k]) begin
      @(negedge clk_in);
      rdy_in = tbl[k].i.rdy; rob_clear = tbl[k].i.clr;
      is_update_val = tbl[k].i.iv; update_val_id = tbl[k].i.vid; update_val_dep = tbl[k].i.vdep; update_val = tbl[k].i.val;
      is_update_dep = tbl[k].i.idp; update_dep_id = tbl[k].i.did; update_dep = tbl[k].i.ddep;
      qry1_reg_id = tbl[k].i.q1; qry2_reg_id = tbl[k].i.q2;
      sb.push_back(tbl[k].e);
      #2;
      if (sb.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL scoreboard empty at vector %0d", k);
        continue;
      end
      e = sb.pop_front();
      chk("qry1_busy", k, 32'(qry1_busy), 32'(e.b1));
      chk("qry1_value", k, qry1_value, e.v1);
      chk("qry2_busy", k, 32'(qry2_busy), 32'(e.b2));
      chk("qry2_value", k, qry2_value, e.v2);
      if (!e.xd) begin
        chk("qry1_dep", k, 32'(qry1_dep), 32'(e.d1));
        chk("qry2_dep", k, 32'(qry2_dep), 32'(e.d2));
      end
      @(posedge clk_in); #1;
      chk("busy_cnt", k, 32'(busy_cnt), 32'(e.cnt));
    end
    @(negedge clk_in);
    idle(); rdy_in = 0; rst_in = 1; qry1_reg_id = 8; qry2_reg_id = 3;
    @(posedge clk_in); #1;
    chk("rst over rdy busy_cnt", -2, 32'(busy_cnt), 0);
    chk("rst over rdy qry1_busy", -2, 32'(qry1_busy), 0);
    chk("rst over rdy qry1_dep", -2, 32'(qry1_dep), 0);
    chk("rst over rdy qry2_value", -2, qry2_value, 0);
    @(negedge clk_in);
    rst_in = 0; rdy_in = 1; is_update_dep = 1; update_dep_id = 31; update_dep = 31; qry1_reg_id = 31; qry2_reg_id = 31;
    @(posedge clk_in); #1;
    idle();
    #1;
    chk("x31 busy after rename", -3, 32'(qry1_busy), 1);
    chk("x31 dep after rename", -3, 32'(qry2_dep), 31);
    chk("x31 busy_cnt", -3, 32'(busy_cnt), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with per-register rename tags, for the out-of-order RISC-V core.
- Holds x0..x31 values plus, per register, a busy bit and the ROB id of its newest in-flight producer.
- Upstream: ROB commit writes values; decoder issue writes rename tags.
- Downstream: two combinational query ports feed the decoder/RS operand fetch (value, or ROB tag to wait on).

Parameters:
- ROB_SIZE_BIT, 5: width of a ROB id (ROB depth 2^ROB_SIZE_BIT).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; state frozen when low
- rob_clear  input  1  misprediction flush from ROB
- is_update_val  input  1  ROB commit writes a register this cycle
- update_val_id  input  5  committed destination register
- update_val_dep  input  ROB_SIZE_BIT  ROB id of the committing entry
- update_val  input  32  committed value
- is_update_dep  input  1  decoder issues an instruction with a destination register
- update_dep_id  input  5  renamed destination register
- update_dep  input  ROB_SIZE_BIT  ROB id allocated to that instruction
- qry1_reg_id  input  5  source register 1 index
- qry1_busy  output  1  source 1 has a pending producer
- qry1_value  output  32  source 1 value (valid when qry1_busy=0)
- qry1_dep  output  ROB_SIZE_BIT  source 1 producer ROB id (valid when qry1_busy=1)
- qry2_reg_id, qry2_busy, qry2_value, qry2_dep: same as port 1, for source 2
- busy_cnt  output  6  registered count of registers with busy=1

Behaviour:
- State: value[32]x32b, busy[32], dep[32]xROB_SIZE_BIT, busy_cnt.
- Reset: rst_in=1 at posedge clears all values, busy bits, deps and busy_cnt to 0. Reset takes priority over rdy_in. Query outputs are then 0/0/0.
- rdy_in=0: no state changes. Queries stay combinational on the current state.
- x0: writes and renames to reg 0 are ignored. Queries of reg 0 always return busy=0, value=0, dep=0.
- Commit (rdy_in, is_update_val, id!=0):
  - value[id] <= update_val unconditionally.
  - busy[id] is cleared only if busy[id]=1 and dep[id]==update_val_dep. Otherwise a newer producer owns the register and busy/dep are unchanged.
- Rename (rdy_in, is_update_dep, id!=0, rob_clear=0): busy[id] <= 1, dep[id] <= update_dep.
- Same-cycle commit and rename of the same register: value is written, and the rename wins (busy=1, dep=update_dep).
- Flush (rdy_in, rob_clear=1):
  - All busy bits are cleared and any rename that cycle is dropped.
  - A commit in the same cycle still writes its value.
  - dep contents don't care.
- busy_cnt: registered, equals the number of set busy bits after the cycle's update. Range 0..31.
- Query (combinational, zero latency):
  - If the current-cycle commit matches (is_update_val, update_val_id==qry id!=0, busy=1, dep==update_val_dep): output busy=0, value=update_val. This is commit bypass.
  - Otherwise output the stored busy/value/dep.
  - A same-cycle rename is NOT forwarded: an instruction reading and writing the same register (add x1,x1,x2) sees the prior mapping.
- Both query ports are independent and may index the same register.

Test Plan:
- Reset, then query x5 on both ports -> busy=0, value=0, dep=0, busy_cnt=0.
- Rename x3->dep 7, next cycle commit x3 dep 7 value 0x12345678 -> during the commit cycle qry1(x3) returns busy=0, value 0x12345678 (bypass). Afterwards busy=0 and busy_cnt returns to 0.
- Rename x4->dep 2, then x4->dep 9, then commit x4 dep 2 value 0xAA -> value[x4]=0xAA but busy=1, dep=9; query returns busy=1, dep=9.
- Commit x6 dep 1 and rename x6->dep 4 in the same cycle -> next cycle busy=1, dep=4, stored value equals the committed value; same-cycle query sees the old mapping.
- Rename x1,x2,x10 (busy_cnt=3), then rob_clear with a simultaneous commit x2 value 0x55 -> all busy=0, busy_cnt=0, value[x2]=0x55.
- Rename/commit to x0 with value 0xFFFFFFFF, and rdy_in=0 during a rename of x8 -> x0 queries return 0; x8 stays not busy.
